// File: rtl/regfile_mp.sv
// Multi-port integer register file for the RISC-V core.
// The block has NUM_RD combinational read ports and two write-back ports.
// On a same-address conflict, wb1 takes priority over wb0.
// An optional forward from the write ports to the read ports is available (BYPASS).
// A per-register busy scoreboard is also kept: issue sets a bit, and write-back clears it.
module regfile_mp #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int AW         = $clog2(NREG),
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   wb0_en,
  input  logic [AW-1:0]          wb0_addr,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic                   wb1_en,
  input  logic [AW-1:0]          wb1_addr,
  input  logic [XLEN-1:0]        wb1_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic                   busy_any
);

  logic [XLEN-1:0] regs_reg  [NREG];
  logic [XLEN-1:0] regs_next [NREG];
  logic [XLEN-1:0] rst_val   [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Per-register next-state: write-port priority and the scoreboard update.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      // x0 is hardwired: it never takes a write and is never marked busy.
      assign rst_val[gi]   = '0;
      assign regs_next[gi] = '0;
      assign busy_next[gi] = 1'b0;
    end else begin : g_xn
      logic wr0_hit;
      logic wr1_hit;
      logic iss_hit;
      assign wr0_hit       = wb0_en   && (wb0_addr == AW'(gi));
      assign wr1_hit       = wb1_en   && (wb1_addr == AW'(gi));
      assign iss_hit       = issue_en && (issue_rd == AW'(gi));
      assign rst_val[gi]   = (INIT_INDEX != 0) ? XLEN'(gi) : '0;
      assign regs_next[gi] = wr1_hit ? wb1_data : (wr0_hit ? wb0_data : regs_reg[gi]);
      // A new issue wins over a clearing write, because a newer producer is now in flight.
      assign busy_next[gi] = iss_hit | (busy_reg[gi] & ~(wr0_hit | wr1_hit));
    end
  end

  // State register. Reset restores contents and the scoreboard immediately, and writes pending during reset are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_reg <= rst_val;
      busy_reg <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
    end
  end

  // Combinational read ports. The optional write forward is applied here; the busy bit is never forwarded.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    assign addr   = rs_addr[gi*AW +: AW];
    assign stored = regs_reg[addr];
    if (BYPASS != 0) begin : g_byp
      logic hit0;
      logic hit1;
      assign hit1 = wb1_en && (wb1_addr == addr) && (addr != '0);
      assign hit0 = wb0_en && (wb0_addr == addr) && (addr != '0);
      assign rs_data[gi*XLEN +: XLEN] = hit1 ? wb1_data : (hit0 ? wb0_data : stored);
    end else begin : g_nobyp
      assign rs_data[gi*XLEN +: XLEN] = stored;
    end
    assign rs_busy[gi] = busy_reg[addr];
  end

  assign busy_any = |busy_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// It drives two instances, one with the forward and one without, from the same stimulus.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2*AW-1:0] rs_addr;
  logic            wb0_en, wb1_en, issue_en;
  logic [AW-1:0]   wb0_addr, wb1_addr, issue_rd;
  logic [XLEN-1:0] wb0_data, wb1_data;

  logic [2*XLEN-1:0] rs_data_b, rs_data_n;
  logic [1:0]        rs_busy_b, rs_busy_n;
  logic              busy_any_b, busy_any_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .BYPASS(1), .INIT_INDEX(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_any(busy_any_b)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .BYPASS(0), .INIT_INDEX(1)) dut_nb (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_any(busy_any_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_en = 1'b0; wb1_en = 1'b0; issue_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  initial begin
    idle();
    wb0_addr = '0; wb1_addr = '0; issue_rd = '0; wb0_data = '0; wb1_data = '0;
    set_rd(5'd5, 5'd31);
    #1 reset = 1'b1;
    #1;
    // Reset contents are visible before any clock edge.
    chk("rst_rd0_b", rs_data_b[31:0],  64'h5);
    chk("rst_rd1_b", rs_data_b[63:32], 64'h1F);
    chk("rst_rd0_n", rs_data_n[31:0],  64'h5);
    chk("rst_busy_any", busy_any_b, 64'h0);
    chk("rst_rs_busy", rs_busy_b, 64'h0);
    tick(); tick();
    reset = 1'b0;
    $display("reset released, reset contents checked");

    // Dual write to the same address: wb1 wins.
    set_rd(5'd7, 5'd0);
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hAAAA0000;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h5555FFFF;
    #1;
    chk("conf_pre_b", rs_data_b[31:0], 64'h5555FFFF);
    chk("conf_pre_n", rs_data_n[31:0], 64'h7);
    tick(); idle(); #1;
    chk("conf_post_b", rs_data_b[31:0], 64'h5555FFFF);
    chk("conf_post_n", rs_data_n[31:0], 64'h5555FFFF);
    $display("dual write conflict on x7 checked");

    // Dual write to different addresses.
    set_rd(5'd3, 5'd4);
    wb0_en = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h22;
    #1;
    chk("dual_pre_b0", rs_data_b[31:0],  64'h11);
    chk("dual_pre_b1", rs_data_b[63:32], 64'h22);
    chk("dual_pre_n0", rs_data_n[31:0],  64'h3);
    chk("dual_pre_n1", rs_data_n[63:32], 64'h4);
    tick(); idle(); #1;
    chk("dual_post_n0", rs_data_n[31:0],  64'h11);
    chk("dual_post_n1", rs_data_n[63:32], 64'h22);
    $display("dual write x3/x4 checked");

    // Forward on and off.
    set_rd(5'd9, 5'd3);
    wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'hDEADBEEF;
    #1;
    chk("byp_pre_b", rs_data_b[31:0], 64'hDEADBEEF);
    chk("byp_pre_n", rs_data_n[31:0], 64'h9);
    tick(); idle(); #1;
    chk("byp_post_b", rs_data_b[31:0], 64'hDEADBEEF);
    chk("byp_post_n", rs_data_n[31:0], 64'hDEADBEEF);
    $display("bypass x9 checked");

    // x0 protection.
    set_rd(5'd0, 5'd0);
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_pre_b", rs_data_b[31:0], 64'h0);
    tick(); idle(); #1;
    chk("x0_post_b", rs_data_b[31:0], 64'h0);
    chk("x0_post_n", rs_data_n[31:0], 64'h0);
    chk("x0_rs_busy", rs_busy_b, 64'h0);
    chk("x0_busy_any", busy_any_b, 64'h0);
    $display("x0 protection checked");

    // Scoreboard: issue, then clear.
    set_rd(5'd12, 5'd3);
    issue_en = 1'b1; issue_rd = 5'd12;
    #1;
    chk("sb_iss_pre", rs_busy_b[0], 64'h0);
    tick(); idle(); #1;
    chk("sb_iss_post", rs_busy_b[0], 64'h1);
    chk("sb_iss_any", busy_any_n, 64'h1);
    chk("sb_other_port", rs_busy_b[1], 64'h0);
    wb1_en = 1'b1; wb1_addr = 5'd12; wb1_data = 32'h00C0FFEE;
    #1;
    chk("sb_clr_pre_busy", rs_busy_b[0], 64'h1);
    chk("sb_clr_pre_data", rs_data_b[31:0], 64'h00C0FFEE);
    tick(); idle(); #1;
    chk("sb_clr_post_busy", rs_busy_b[0], 64'h0);
    chk("sb_clr_post_any", busy_any_b, 64'h0);
    chk("sb_clr_post_data", rs_data_n[31:0], 64'h00C0FFEE);
    $display("scoreboard issue/clear x12 checked");

    // Set and clear in the same cycle: set wins and data is stored.
    issue_en = 1'b1; issue_rd = 5'd12;
    wb0_en = 1'b1; wb0_addr = 5'd12; wb0_data = 32'h0000BBBB;
    tick(); idle(); #1;
    chk("sb_both_busy", rs_busy_b[0], 64'h1);
    chk("sb_both_data", rs_data_n[31:0], 64'h0000BBBB);
    // Issue to an already busy register: the bit stays set and nothing is counted.
    issue_en = 1'b1; issue_rd = 5'd12;
    tick(); idle(); #1;
    chk("sb_reissue", rs_busy_n[0], 64'h1);
    wb0_en = 1'b1; wb0_addr = 5'd12; wb0_data = 32'h1;
    tick(); idle(); #1;
    chk("sb_single_clr", rs_busy_b[0], 64'h0);
    // Write to a register that is not busy.
    set_rd(5'd20, 5'd12);
    wb1_en = 1'b1; wb1_addr = 5'd20; wb1_data = 32'h2020;
    tick(); idle(); #1;
    chk("sb_nb_write_busy", rs_busy_b, 64'h0);
    chk("sb_nb_write_data", rs_data_n[31:0], 64'h2020);
    $display("scoreboard set/clear priority checked");

    // Reset asserted between edges.
    set_rd(5'd15, 5'd7);
    wb0_en = 1'b1; wb0_addr = 5'd15; wb0_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd15;
    tick(); idle(); #1;
    chk("mid_pre_data", rs_data_n[31:0], 64'h1234);
    chk("mid_pre_any", busy_any_b, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data_b", rs_data_b[31:0], 64'hF);
    chk("mid_rst_data_n", rs_data_n[31:0], 64'hF);
    chk("mid_rst_x7", rs_data_b[63:32], 64'h7);
    chk("mid_rst_any", busy_any_b, 64'h0);
    // A write that is pending while reset is held is lost.
    wb0_en = 1'b1; wb0_addr = 5'd15; wb0_data = 32'h9999;
    tick(); idle(); #1;
    reset = 1'b0;
    #1;
    chk("mid_lost_write", rs_data_b[31:0], 64'hF);
    chk("mid_lost_any", busy_any_n, 64'h0);
    $display("mid-operation reset checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
